// File: rtl/axi_10g_ethernet_0_tcp_active_open_manager_pkg.sv
// Shared definitions for the client-side TCP connection manager.
//  - tcp_state_e : connection states, encoded as reported on tcp_state
//  - FLAG_*      : bit positions inside the 4-bit {FIN,SYN,RST,ACK} flag field
//  - TX_*        : flag patterns of the control segments this block requests
//  - bswap32     : host <-> network byte order
//  - seq_lt/le   : serial-number comparison (RFC 1982 style, 32-bit wrap)
package axi_10g_ethernet_0_tcp_active_open_manager_pkg;

  // Local endpoint identity; the TX framer stamps these on outgoing segments.
  localparam logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd2, 8'd20};
  localparam logic [15:0] BOARD_PORT = 16'h0024;

  localparam int unsigned RETRY_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_SYN_SENT    = 4'd2,
    ST_ESTABLISHED = 4'd3,
    ST_FIN_WAIT_1  = 4'd4,
    ST_FIN_WAIT_2  = 4'd5,
    ST_LAST_ACK    = 4'd7,
    ST_TIME_WAIT   = 4'd8
  } tcp_state_e;

  localparam int unsigned FLAG_ACK = 0;
  localparam int unsigned FLAG_RST = 1;
  localparam int unsigned FLAG_SYN = 2;
  localparam int unsigned FLAG_FIN = 3;

  localparam logic [3:0] TX_SYN     = 4'b0100;
  localparam logic [3:0] TX_ACK     = 4'b0001;
  localparam logic [3:0] TX_FIN_ACK = 4'b1001;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // a < b in sequence space: the wrapped difference a-b is negative.
  function automatic logic seq_lt(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = a - b;
    return diff[31];
  endfunction

  function automatic logic seq_le(input logic [31:0] a, input logic [31:0] b);
    return (a == b) || seq_lt(a, b);
  endfunction

endpackage

// File: rtl/axi_10g_ethernet_0_tcp_active_open_manager_retx_timer.sv
// SYN/FIN retransmission timer with retry counter.
//  aclk, areset : clock, synchronous active-high reset
//  start        : (re)start the timeout from zero; the control segment just left
//  stop         : halt the timer and clear the retry count (connection state changed)
//  expire       : high for the one cycle the timeout elapses; the timer then idles
//  retry        : number of expiries since the last stop (saturating)
module axi_10g_ethernet_0_tcp_active_open_manager_retx_timer
  import axi_10g_ethernet_0_tcp_active_open_manager_pkg::*;
#(
  parameter int unsigned RTO_CYCLES = 1562500
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               start,
  input  logic               stop,
  output logic               expire,
  output logic [RETRY_W-1:0] retry
);

  localparam int unsigned CNT_W = $clog2(RTO_CYCLES + 1);

  logic               running_q, running_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  assign expire = running_q && (cnt_q == CNT_W'(RTO_CYCLES - 1));
  assign retry  = retry_q;

  always_comb begin
    running_d = running_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    if (stop) begin
      running_d = 1'b0;
      cnt_d     = '0;
      retry_d   = '0;
    end else if (start) begin
      running_d = 1'b1;
      cnt_d     = '0;
    end else if (expire) begin
      // Idle until the retransmitted segment is actually handed to the framer.
      running_d = 1'b0;
      cnt_d     = '0;
      if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
    end else if (running_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      retry_q   <= '0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
    end
  end

endmodule

// File: rtl/axi_10g_ethernet_0_tcp_active_open_manager.sv
// Client-side TCP connection manager: active open (SYN handshake), sequence
// tracking during data transfer, active and passive close.
//  aclk, areset               : clock, synchronous active-high reset
//  connect_req / close_req    : open to dst_* (IDLE only) / active close (ESTABLISHED only)
//  dst_ip, dst_mac, dst_port  : peer address, latched on an accepted connect_req
//  rx_*                       : one parsed segment per rx_valid strobe (seq/ack network order)
//  tx_data_done, tx_data_len  : payload bytes the data engine has sent
//  tx_valid/tx_ready/tx_flags : single-entry control-segment request to the framer
//  seq_number_local, ack_number_local, acked_number : SND.NXT, RCV.NXT, SND.UNA (network order)
//  tx_ip, tx_mac, tx_port     : latched peer address
//  tcp_state                  : current connection state
//  established_moment, connect_fail, closed_moment : one-cycle event pulses
module axi_10g_ethernet_0_tcp_active_open_manager
  import axi_10g_ethernet_0_tcp_active_open_manager_pkg::*;
#(
  parameter logic [31:0] ISS              = 32'h0000_1000,
  parameter int unsigned RTO_CYCLES       = 1562500,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned TIME_WAIT_CYCLES = 15625
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        connect_req,
  input  logic        close_req,
  input  logic [31:0] dst_ip,
  input  logic [47:0] dst_mac,
  input  logic [15:0] dst_port,
  input  logic        rx_valid,
  input  logic        rx_syn,
  input  logic        rx_ack,
  input  logic        rx_fin,
  input  logic        rx_rst,
  input  logic [31:0] rx_seq_number,
  input  logic [31:0] rx_ack_number,
  input  logic [31:0] rx_ip,
  input  logic [15:0] rx_port,
  input  logic [15:0] rx_data_len,
  input  logic        tx_data_done,
  input  logic [15:0] tx_data_len,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [3:0]  tx_flags,
  output logic [31:0] seq_number_local,
  output logic [31:0] ack_number_local,
  output logic [31:0] acked_number,
  output logic [31:0] tx_ip,
  output logic [47:0] tx_mac,
  output logic [15:0] tx_port,
  output logic [3:0]  tcp_state,
  output logic        established_moment,
  output logic        connect_fail,
  output logic        closed_moment
);

  localparam int unsigned TW_W = $clog2(TIME_WAIT_CYCLES + 1);

  tcp_state_e  state_q, state_d;
  logic [31:0] seq_q, seq_d;      // SND.NXT, host order
  logic [31:0] una_q, una_d;      // SND.UNA
  logic [31:0] ack_q, ack_d;      // RCV.NXT
  logic [31:0] ip_q, ip_d;
  logic [47:0] mac_q, mac_d;
  logic [15:0] port_q, port_d;
  logic        tx_valid_q, tx_valid_d;
  logic [3:0]  tx_flags_q, tx_flags_d;
  logic        est_q, est_d;
  logic        fail_q, fail_d;
  logic        closed_q, closed_d;
  logic [TW_W-1:0] tw_cnt_q, tw_cnt_d;

  logic        req;
  logic [3:0]  req_flags;
  logic        drop;

  logic        rto_expire;
  logic [RETRY_W-1:0] retry;
  logic        retry_left;
  logic        tx_fire;
  logic        timer_start;
  logic        timer_stop;

  logic        rx_match;
  logic [31:0] rx_seq_h;
  logic [31:0] rx_ack_h;
  logic        acks_all;
  logic        in_order;

  assign rx_seq_h   = bswap32(rx_seq_number);
  assign rx_ack_h   = bswap32(rx_ack_number);
  assign rx_match   = rx_valid && (rx_ip == ip_q) && (rx_port == port_q);
  assign acks_all   = rx_ack && (rx_ack_h == seq_q);
  assign in_order   = (rx_seq_h == ack_q);
  assign retry_left = retry < RETRY_W'(MAX_RETRY);

  assign tx_fire     = tx_valid_q && tx_ready;
  assign timer_start = tx_fire && (tx_flags_q[FLAG_SYN] || tx_flags_q[FLAG_FIN]);
  assign timer_stop  = (state_d != state_q);

  axi_10g_ethernet_0_tcp_active_open_manager_retx_timer #(
    .RTO_CYCLES (RTO_CYCLES)
  ) u_retx_timer (
    .aclk   (aclk),
    .areset (areset),
    .start  (timer_start),
    .stop   (timer_stop),
    .expire (rto_expire),
    .retry  (retry)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    state_d    = state_q;
    seq_d      = seq_q;
    una_d      = una_q;
    ack_d      = ack_q;
    ip_d       = ip_q;
    mac_d      = mac_q;
    port_d     = port_q;
    tx_valid_d = tx_valid_q && !tx_ready;
    tx_flags_d = tx_flags_q;
    est_d      = 1'b0;
    fail_d     = 1'b0;
    closed_d   = 1'b0;
    tw_cnt_d   = tw_cnt_q;
    req        = 1'b0;
    req_flags  = '0;
    drop       = 1'b0;

    if (rx_match && rx_rst && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      drop    = 1'b1;
      fail_d  = (state_q == ST_SYN_SENT);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (connect_req) begin
            ip_d      = dst_ip;
            mac_d     = dst_mac;
            port_d    = dst_port;
            seq_d     = ISS;
            una_d     = ISS;
            req       = 1'b1;
            req_flags = TX_SYN;
            state_d   = ST_SYN_SENT;
          end
        end

        ST_SYN_SENT: begin
          if (rx_match && rx_syn && rx_ack && (rx_ack_h == ISS + 32'd1)) begin
            ack_d     = rx_seq_h + 32'd1;
            seq_d     = ISS + 32'd1;
            una_d     = ISS + 32'd1;
            req       = 1'b1;
            req_flags = TX_ACK;
            state_d   = ST_ESTABLISHED;
            est_d     = 1'b1;
          end else if (rto_expire) begin
            if (retry_left) begin
              req       = 1'b1;
              req_flags = TX_SYN;
            end else begin
              state_d = ST_IDLE;
              fail_d  = 1'b1;
              drop    = 1'b1;
            end
          end
        end

        ST_ESTABLISHED: begin
          if (tx_data_done) seq_d = seq_q + {16'd0, tx_data_len};
          if (rx_match && rx_ack && seq_lt(una_q, rx_ack_h) && seq_le(rx_ack_h, seq_q))
            una_d = rx_ack_h;
          // A peer FIN wins over a close_req arriving in the same cycle.
          if (rx_match && in_order && rx_fin) begin
            ack_d     = ack_q + {16'd0, rx_data_len} + 32'd1;
            seq_d     = seq_d + 32'd1;
            req       = 1'b1;
            req_flags = TX_FIN_ACK;
            state_d   = ST_LAST_ACK;
          end else begin
            if (rx_match && in_order) begin
              ack_d = ack_q + {16'd0, rx_data_len};
              if (rx_data_len != 16'd0) begin
                req       = 1'b1;
                req_flags = TX_ACK;
              end
            end
            if (close_req) begin
              seq_d     = seq_d + 32'd1;
              req       = 1'b1;
              req_flags = TX_FIN_ACK;
              state_d   = ST_FIN_WAIT_1;
            end
          end
        end

        ST_FIN_WAIT_1: begin
          if (rx_match && acks_all) una_d = rx_ack_h;
          if (rx_match && rx_fin) begin
            // Without our FIN acked this is a simultaneous close: ACK it and keep waiting.
            ack_d     = ack_q + 32'd1;
            req       = 1'b1;
            req_flags = TX_ACK;
            if (acks_all) begin
              state_d  = ST_TIME_WAIT;
              tw_cnt_d = '0;
            end
          end else if (rx_match && acks_all) begin
            state_d = ST_FIN_WAIT_2;
          end else if (rto_expire) begin
            if (retry_left) begin
              req       = 1'b1;
              req_flags = TX_FIN_ACK;
            end else begin
              state_d  = ST_IDLE;
              closed_d = 1'b1;
              drop     = 1'b1;
            end
          end
        end

        ST_FIN_WAIT_2: begin
          if (rx_match && rx_fin) begin
            ack_d     = ack_q + 32'd1;
            req       = 1'b1;
            req_flags = TX_ACK;
            state_d   = ST_TIME_WAIT;
            tw_cnt_d  = '0;
          end
        end

        ST_LAST_ACK: begin
          if (rx_match && acks_all) begin
            una_d    = rx_ack_h;
            state_d  = ST_IDLE;
            closed_d = 1'b1;
          end else if (rto_expire) begin
            if (retry_left) begin
              req       = 1'b1;
              req_flags = TX_FIN_ACK;
            end else begin
              state_d = ST_IDLE;
              drop    = 1'b1;
            end
          end
        end

        ST_TIME_WAIT: begin
          // A retransmitted FIN means our last ACK was lost: re-ACK and restart the dwell.
          if (rx_match && rx_fin) begin
            req       = 1'b1;
            req_flags = TX_ACK;
            tw_cnt_d  = '0;
          end else if (tw_cnt_q == TW_W'(TIME_WAIT_CYCLES - 1)) begin
            state_d  = ST_IDLE;
            closed_d = 1'b1;
          end else begin
            tw_cnt_d = tw_cnt_q + TW_W'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    // Single-entry slot: a new request overwrites whatever is still pending.
    if (drop) begin
      tx_valid_d = 1'b0;
    end else if (req) begin
      tx_valid_d = 1'b1;
      tx_flags_d = req_flags;
    end
  end

  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
    if (areset) begin
      state_q    <= ST_IDLE;
      seq_q      <= '0;
      una_q      <= '0;
      ack_q      <= '0;
      ip_q       <= '0;
      mac_q      <= '0;
      port_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_flags_q <= '0;
      est_q      <= 1'b0;
      fail_q     <= 1'b0;
      closed_q   <= 1'b0;
      tw_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      una_q      <= una_d;
      ack_q      <= ack_d;
      ip_q       <= ip_d;
      mac_q      <= mac_d;
      port_q     <= port_d;
      tx_valid_q <= tx_valid_d;
      tx_flags_q <= tx_flags_d;
      est_q      <= est_d;
      fail_q     <= fail_d;
      closed_q   <= closed_d;
      tw_cnt_q   <= tw_cnt_d;
    end
  end

  assign tx_valid           = tx_valid_q;
  assign tx_flags           = tx_flags_q;
  assign seq_number_local   = bswap32(seq_q);
  assign ack_number_local   = bswap32(ack_q);
  assign acked_number       = bswap32(una_q);
  assign tx_ip              = ip_q;
  assign tx_mac             = mac_q;
  assign tx_port            = port_q;
  assign tcp_state          = state_q;
  assign established_moment = est_q;
  assign connect_fail       = fail_q;
  assign closed_moment      = closed_q;

endmodule

// File: tb/tb_axi_10g_ethernet_0_tcp_active_open_manager.sv
module tb_axi_10g_ethernet_0_tcp_active_open_manager;

  localparam logic [31:0] ISS  = 32'h0000_1000;
  localparam int          RTO  = 64;
  localparam int          TW   = 40;
  localparam int          MAXR = 3;

  localparam logic [3:0] F_SYN     = 4'b0100;
  localparam logic [3:0] F_ACK     = 4'b0001;
  localparam logic [3:0] F_FIN_ACK = 4'b1001;

  logic        aclk = 1'b0;
  logic        areset;
  logic        connect_req, close_req;
  logic [31:0] dst_ip;
  logic [47:0] dst_mac;
  logic [15:0] dst_port;
  logic        rx_valid, rx_syn, rx_ack, rx_fin, rx_rst;
  logic [31:0] rx_seq_number, rx_ack_number, rx_ip;
  logic [15:0] rx_port, rx_data_len;
  logic        tx_data_done;
  logic [15:0] tx_data_len;
  logic        tx_valid, tx_ready;
  logic [3:0]  tx_flags;
  logic [31:0] seq_number_local, ack_number_local, acked_number, tx_ip;
  logic [47:0] tx_mac;
  logic [15:0] tx_port;
  logic [3:0]  tcp_state;
  logic        established_moment, connect_fail, closed_moment;

  axi_10g_ethernet_0_tcp_active_open_manager #(
    .ISS              (ISS),
    .RTO_CYCLES       (RTO),
    .MAX_RETRY        (MAXR),
    .TIME_WAIT_CYCLES (TW)
  ) u_dut (
    .aclk               (aclk),
    .areset             (areset),
    .connect_req        (connect_req),
    .close_req          (close_req),
    .dst_ip             (dst_ip),
    .dst_mac            (dst_mac),
    .dst_port           (dst_port),
    .rx_valid           (rx_valid),
    .rx_syn             (rx_syn),
    .rx_ack             (rx_ack),
    .rx_fin             (rx_fin),
    .rx_rst             (rx_rst),
    .rx_seq_number      (rx_seq_number),
    .rx_ack_number      (rx_ack_number),
    .rx_ip              (rx_ip),
    .rx_port            (rx_port),
    .rx_data_len        (rx_data_len),
    .tx_data_done       (tx_data_done),
    .tx_data_len        (tx_data_len),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .tx_flags           (tx_flags),
    .seq_number_local   (seq_number_local),
    .ack_number_local   (ack_number_local),
    .acked_number       (acked_number),
    .tx_ip              (tx_ip),
    .tx_mac             (tx_mac),
    .tx_port            (tx_port),
    .tcp_state          (tcp_state),
    .established_moment (established_moment),
    .connect_fail       (connect_fail),
    .closed_moment      (closed_moment)
  );

  always #5 aclk = ~aclk;

  int unsigned cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference connection model: plain sequence-space bookkeeping.
  logic [31:0] exp_seq, exp_ack, exp_una;
  logic [31:0] peer_ip, peer_isn;
  logic [15:0] peer_port;
  logic [47:0] peer_mac;
  int unsigned accept_cyc, seen_cyc;

  function automatic logic [31:0] net(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = x[8*(3-b) +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and finish just after a falling edge.
  task automatic seg(input logic syn, input logic ack, input logic fin, input logic rst,
                     input logic [31:0] s, input logic [31:0] a, input logic [15:0] len,
                     input logic [31:0] ip, input logic [15:0] port);
    rx_syn = syn; rx_ack = ack; rx_fin = fin; rx_rst = rst;
    rx_seq_number = net(s); rx_ack_number = net(a); rx_data_len = len;
    rx_ip = ip; rx_port = port; rx_valid = 1'b1;
    @(negedge aclk);
    rx_valid = 1'b0; rx_syn = 1'b0; rx_ack = 1'b0; rx_fin = 1'b0; rx_rst = 1'b0;
  endtask

  task automatic peer_seg(input logic syn, input logic ack, input logic fin, input logic rst,
                          input logic [31:0] s, input logic [31:0] a, input logic [15:0] len);
    seg(syn, ack, fin, rst, s, a, len, peer_ip, peer_port);
  endtask

  task automatic expect_tx(input string tag, input logic [3:0] flags, input int stall);
    int waited = 0;
    while (tx_valid !== 1'b1 && waited < 4*RTO) begin
      @(negedge aclk);
      waited++;
    end
    seen_cyc = cyc;
    check({tag, " tx_valid"}, 64'(tx_valid), 64'(1));
    check({tag, " tx_flags"}, 64'(tx_flags), 64'(flags));
    for (int k = 0; k < stall; k++) begin
      @(negedge aclk);
      check({tag, " held"}, 64'({tx_valid, tx_flags}), 64'({1'b1, flags}));
    end
    tx_ready = 1'b1;
    @(negedge aclk);
    tx_ready = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic wait_event(input bit want_fail, input int bound,
                            output int unsigned at, output bit seen);
    seen = 1'b0;
    at   = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      if ((want_fail ? connect_fail : closed_moment) === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end else begin
        @(negedge aclk);
      end
    end
  endtask

  task automatic open_conn(input int idx);
    peer_ip   = $urandom;
    peer_port = 16'($urandom);
    peer_mac  = {16'($urandom), 32'($urandom)};
    dst_ip = peer_ip; dst_port = peer_port; dst_mac = peer_mac;
    connect_req = 1'b1;
    @(negedge aclk);
    connect_req = 1'b0;
    exp_seq = ISS;
    exp_una = ISS;
    check("open state", 64'(tcp_state), 64'(2));
    check("open seq", 64'(seq_number_local), 64'(net(ISS)));
    check("open tx_ip", 64'(tx_ip), 64'(peer_ip));
    check("open tx_mac", 64'(tx_mac), 64'(peer_mac));
    check("open tx_port", 64'(tx_port), 64'(peer_port));
    if (idx == 0) peer_isn = 32'h0000_5000;
    else if (idx == 1) peer_isn = 32'hFFFF_FF80;
    else peer_isn = $urandom;
  endtask

  task automatic handshake();
    peer_seg(1, 1, 0, 0, peer_isn, ISS + 2, 0);
    check("bad ack ignored", 64'(tcp_state), 64'(2));
    seg(1, 1, 0, 0, peer_isn, ISS + 1, 0, peer_ip ^ 32'h1, peer_port);
    check("foreign ignored", 64'(tcp_state), 64'(2));
    peer_seg(1, 1, 0, 0, peer_isn, ISS + 1, 0);
    exp_seq = ISS + 1;
    exp_una = ISS + 1;
    exp_ack = peer_isn + 1;
    check("est pulse", 64'(established_moment), 64'(1));
    check("est state", 64'(tcp_state), 64'(3));
    check("est ack_local", 64'(ack_number_local), 64'(net(exp_ack)));
    check("est seq", 64'(seq_number_local), 64'(net(exp_seq)));
    check("est una", 64'(acked_number), 64'(net(exp_una)));
  endtask

  initial begin
    int unsigned at, tw_entry;
    bit seen;
    logic [15:0] len;
    logic [31:0] a;

    areset = 1'b1;
    connect_req = 0; close_req = 0; dst_ip = 0; dst_mac = 0; dst_port = 0;
    rx_valid = 0; rx_syn = 0; rx_ack = 0; rx_fin = 0; rx_rst = 0;
    rx_seq_number = 0; rx_ack_number = 0; rx_ip = 0; rx_port = 0; rx_data_len = 0;
    tx_data_done = 0; tx_data_len = 0; tx_ready = 0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("reset state", 64'(tcp_state), 64'(0));
    check("reset tx_valid", 64'(tx_valid), 64'(0));
    check("reset seq", 64'(seq_number_local), 64'(0));
    check("reset ack", 64'(ack_number_local), 64'(0));
    check("reset una", 64'(acked_number), 64'(0));
    check("reset tx_ip", 64'(tx_ip), 64'(0));

    for (int i = 0; i < 6; i++) begin
      open_conn(i);
      expect_tx("syn", F_SYN, $urandom_range(0, 3));
      handshake();
      expect_tx("hs ack", F_ACK, $urandom_range(0, 3));
      check("est pulse gone", 64'(established_moment), 64'(0));

      for (int k = 0; k < 10; k++) begin
        int op;
        op = (i == 0 && k == 0) ? 0 : int'($urandom_range(0, 3));
        case (op)
          0: begin
            len = (i == 0 && k == 0) ? 16'd100 : 16'($urandom_range(0, 1500));
            peer_seg(0, 1, 0, 0, exp_ack, exp_una, len);
            exp_ack = exp_ack + 32'(len);
            check("data ack_local", 64'(ack_number_local), 64'(net(exp_ack)));
            if (len != 0) expect_tx("data ack", F_ACK, $urandom_range(0, 2));
            else check("empty seg no tx", 64'(tx_valid), 64'(0));
          end
          1: begin
            peer_seg(0, 1, 0, 0, exp_ack + 1 + $urandom_range(0, 5000), exp_una, 16'd50);
            check("ooo ack_local", 64'(ack_number_local), 64'(net(exp_ack)));
            check("ooo no tx", 64'(tx_valid), 64'(0));
          end
          2: begin
            len = 16'($urandom_range(1, 1500));
            tx_data_done = 1'b1; tx_data_len = len;
            @(negedge aclk);
            tx_data_done = 1'b0;
            exp_seq = exp_seq + 32'(len);
            check("tx_done seq", 64'(seq_number_local), 64'(net(exp_seq)));
          end
          default: begin
            if ($urandom_range(0, 1) == 0) begin
              a = exp_una + $urandom_range(0, exp_seq - exp_una);
              exp_una = a;
            end else begin
              a = exp_seq + 5;
            end
            peer_seg(0, 1, 0, 0, exp_ack, a, 0);
            check("una", 64'(acked_number), 64'(net(exp_una)));
          end
        endcase
        check("est hold", 64'(tcp_state), 64'(3));
      end

      if (i % 2 == 0) begin
        close_req = 1'b1;
        @(negedge aclk);
        close_req = 1'b0;
        exp_seq = exp_seq + 1;
        check("fw1 state", 64'(tcp_state), 64'(4));
        check("fw1 seq", 64'(seq_number_local), 64'(net(exp_seq)));
        expect_tx("fin", F_FIN_ACK, (i == 0) ? 10 : int'($urandom_range(0, 3)));
        peer_seg(0, 1, 0, 0, exp_ack, exp_seq, 0);
        check("fw2 state", 64'(tcp_state), 64'(5));
        check("fw2 una", 64'(acked_number), 64'(net(exp_seq)));
        peer_seg(0, 1, 1, 0, exp_ack, exp_seq, 0);
        tw_entry = cyc;
        exp_ack = exp_ack + 1;
        check("tw state", 64'(tcp_state), 64'(8));
        check("tw ack_local", 64'(ack_number_local), 64'(net(exp_ack)));
        expect_tx("tw ack", F_ACK, $urandom_range(0, 3));
        wait_event(1'b0, TW + 20, at, seen);
        check("tw closed seen", 64'(seen), 64'(1));
        check("tw dwell", 64'(at - tw_entry), 64'(TW));
        check("tw idle", 64'(tcp_state), 64'(0));
      end else begin
        len = 16'($urandom_range(0, 64));
        peer_seg(0, 1, 1, 0, exp_ack, exp_una, len);
        exp_ack = exp_ack + 32'(len) + 1;
        exp_seq = exp_seq + 1;
        check("last_ack state", 64'(tcp_state), 64'(7));
        check("last_ack ack_local", 64'(ack_number_local), 64'(net(exp_ack)));
        check("last_ack seq", 64'(seq_number_local), 64'(net(exp_seq)));
        expect_tx("pfin", F_FIN_ACK, $urandom_range(0, 3));
        peer_seg(0, 1, 0, 0, exp_ack, exp_seq, 0);
        check("passive closed", 64'(closed_moment), 64'(1));
        check("passive idle", 64'(tcp_state), 64'(0));
        check("passive una", 64'(acked_number), 64'(net(exp_seq)));
      end
    end

    // RST while established drops the pending handshake ACK.
    open_conn(7);
    expect_tx("rst syn", F_SYN, 0);
    handshake();
    peer_seg(0, 0, 0, 1, exp_ack, 0, 0);
    check("rst est state", 64'(tcp_state), 64'(0));
    check("rst est tx_valid", 64'(tx_valid), 64'(0));
    check("rst est no fail", 64'(connect_fail), 64'(0));

    // RST in SYN_SENT reports connect_fail.
    open_conn(8);
    expect_tx("rst2 syn", F_SYN, 0);
    peer_seg(0, 1, 0, 1, 0, ISS + 1, 0);
    check("rst syn_sent state", 64'(tcp_state), 64'(0));
    check("rst syn_sent fail", 64'(connect_fail), 64'(1));

    // SYN loss: three retransmits one RTO apart, then give up.
    open_conn(9);
    expect_tx("loss syn", F_SYN, 0);
    for (int r = 0; r < MAXR; r++) begin
      at = accept_cyc;
      expect_tx("loss resend", F_SYN, 0);
      check("loss rto", 64'(seen_cyc - at), 64'(RTO));
    end
    at = accept_cyc;
    wait_event(1'b1, 4*RTO, tw_entry, seen);
    check("loss fail seen", 64'(seen), 64'(1));
    check("loss fail rto", 64'(tw_entry - at), 64'(RTO));
    check("loss idle", 64'(tcp_state), 64'(0));

    // Synchronous reset in FIN_WAIT_1 clears everything.
    open_conn(10);
    expect_tx("ar syn", F_SYN, 0);
    handshake();
    close_req = 1'b1;
    @(negedge aclk);
    close_req = 1'b0;
    check("ar fw1", 64'(tcp_state), 64'(4));
    areset = 1'b1;
    @(negedge aclk);
    check("ar state", 64'(tcp_state), 64'(0));
    check("ar tx_valid", 64'(tx_valid), 64'(0));
    check("ar flags", 64'(tx_flags), 64'(0));
    check("ar seq", 64'(seq_number_local), 64'(0));
    check("ar ack", 64'(ack_number_local), 64'(0));
    check("ar una", 64'(acked_number), 64'(0));
    check("ar addr", 64'({tx_ip, tx_port}), 64'(0));
    check("ar mac", 64'(tx_mac), 64'(0));
    areset = 1'b0;
    @(negedge aclk);
    check("ar after", 64'(tcp_state), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
